shift_reg_n: RTL and testbench

- Parametrised successor to the lab 8-bit load/shift-right/ASR register.
- Generalised to WIDTH bits, with four shift modes (logical right, arithmetic right, logical left, rotate right) and a multi-bit shift amount.
- Shifts one bit per clock under a start/busy/done handshake.
- Sits between the switch/key front-end and the LEDR/HEX display logic, or feeds any datapath that needs timed serial shifting.

---
 rtl/shift_reg_pkg.sv | 14 +
 rtl/shift_step.sv | 45 ++++
 rtl/shift_reg_n.sv | 106 ++++++++++
 tb/tb_shift_reg_n.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the shift_reg_n block: shift modes and FSM states.
// Build option SHIFT_REG_BARREL_EN (see shift_reg_n) does not change these values.
package shift_reg_pkg;

    localparam logic [1:0] OP_LSR = 2'd0;
    localparam logic [1:0] OP_ASR = 2'd1;
    localparam logic [1:0] OP_LSL = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// One single-bit shift step for any of the four modes; purely combinational.
// Used alone for the serial build and chained for the SHIFT_REG_BARREL_EN build.
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    logic signed [WIDTH-1:0] q_signed;

    assign q_signed = q;

    always_comb begin
        q_next  = q;
        out_bit = q[0];
        case (op)
            OP_LSR: begin
                q_next  = {1'b0, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ASR: begin
                q_next  = q_signed >>> 1;
                out_bit = q[0];
            end
            OP_LSL: begin
                q_next  = {q[WIDTH-2:0], 1'b0};
                out_bit = q[WIDTH-1];
            end
            OP_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                q_next  = q;
                out_bit = q[0];
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_n.sv
// Load / multi-mode shift register with start/busy/done handshake, one bit per clock.
// Define SHIFT_REG_BARREL_EN to finish the whole shift in a single SHIFT cycle.
module shift_reg_n
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic             serial_out,
    output logic [WIDTH-1:0] q
);

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] step_q;
    logic             step_bit;

`ifdef SHIFT_REG_BARREL_EN
    localparam int MAX_AMT = (1 << AMT_W) - 1;

    // stage_q[i] is q after i literal steps; cnt holds the latched amount
    logic [WIDTH-1:0] stage_q   [0:MAX_AMT];
    logic             stage_bit [0:MAX_AMT];

    assign stage_q[0]   = q;
    assign stage_bit[0] = serial_out;

    for (genvar i = 0; i < MAX_AMT; i++) begin : g_chain
        shift_step #(.WIDTH(WIDTH)) u_step (
            .q       (stage_q[i]),
            .op      (op_r),
            .q_next  (stage_q[i+1]),
            .out_bit (stage_bit[i+1])
        );
    end

    assign step_q   = stage_q[cnt];
    assign step_bit = stage_bit[cnt];
`else
    shift_step #(.WIDTH(WIDTH)) u_step (
        .q       (q),
        .op      (op_r),
        .q_next  (step_q),
        .out_bit (step_bit)
    );
`endif

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            op_r       <= OP_LSR;
            cnt        <= '0;
            q          <= '0;
            serial_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!load_n) begin
                        q <= load_val;
                    end else if (start) begin
                        if (amount == '0) begin
                            state <= ST_DONE;
                        end else begin
                            op_r  <= op;
                            cnt   <= amount;
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    q          <= step_q;
                    serial_out <= step_bit;
`ifdef SHIFT_REG_BARREL_EN
                    cnt   <= '0;
                    state <= ST_DONE;
`else
                    cnt <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_n.sv
// Randomised self-checking bench for shift_reg_n against a closed-form shift model.
// Honours SHIFT_REG_BARREL_EN for the expected busy length.
module tb_shift_reg_n;

    localparam int W     = 8;
    localparam int AW    = 4;
    localparam int MASK  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load_n;
    logic [W-1:0]  load_val;
    logic          start;
    logic [1:0]    op;
    logic [AW-1:0] amount;
    logic          busy;
    logic          done;
    logic          serial_out;
    logic [W-1:0]  q;

    int total = 0;
    int bad   = 0;
    int mq    = 0;
    int ms    = 0;

    shift_reg_n #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_n     (load_n),
        .load_val   (load_val),
        .start      (start),
        .op         (op),
        .amount     (amount),
        .busy       (busy),
        .done       (done),
        .serial_out (serial_out),
        .q          (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // closed-form result of k literal steps applied to the model register
    function automatic void model_shift(input int o, input int k);
        int sign, sv, r;
        if (k == 0) return;
        sign = (mq >> (W - 1)) & 1;
        case (o)
            0: begin
                ms = (k <= W) ? ((mq >> (k - 1)) & 1) : 0;
                mq = (k >= W) ? 0 : (mq >> k);
            end
            1: begin
                ms = (k <= W) ? ((mq >> (k - 1)) & 1) : sign;
                sv = sign ? (mq - (1 << W)) : mq;
                mq = (k >= W) ? (sign ? MASK : 0) : ((sv >>> k) & MASK);
            end
            2: begin
                ms = (k <= W) ? ((mq >> (W - k)) & 1) : 0;
                mq = (mq << k) & MASK;
            end
            default: begin
                r  = k % W;
                ms = (mq >> ((k - 1) % W)) & 1;
                mq = ((mq >> r) | (mq << (W - r))) & MASK;
            end
        endcase
    endfunction

    task automatic do_load(input int v, input logic with_start);
        @(negedge clk);
        load_n   = 1'b0;
        load_val = W'(v);
        start    = with_start;
        amount   = AW'($urandom_range(1, 15));
        op       = 2'($urandom);
        @(posedge clk);
        #1;
        load_n = 1'b1;
        start  = 1'b0;
        mq     = v & MASK;
        @(negedge clk);
        chk("load_q", q, mq);
        chk("load_serial", serial_out, ms);
        chk("load_busy", busy, 0);
        chk("load_done", done, 0);
        if (with_start) begin
            @(negedge clk);
            chk("load_start_done", done, 0);
            chk("load_start_busy", busy, 0);
        end
    endtask

    task automatic run_op(input int o, input int k);
        int exp_busy, nbusy, done_at;
        bit both;
`ifdef SHIFT_REG_BARREL_EN
        exp_busy = (k > 0) ? 1 : 0;
`else
        exp_busy = k;
`endif
        @(negedge clk);
        op     = 2'(o);
        amount = AW'(k);
        start  = 1'b1;
        load_n = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 2'($urandom);
        amount = AW'($urandom);
        nbusy   = 0;
        done_at = 0;
        both    = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy && done) both = 1'b1;
            if (busy) begin
                nbusy++;
                load_n   = 1'($urandom);
                load_val = W'($urandom);
                start    = 1'($urandom);
                op       = 2'($urandom);
                amount   = AW'($urandom);
            end else begin
                load_n = 1'b1;
                start  = 1'($urandom);
            end
            if (done) begin
                done_at = c;
                break;
            end
        end
        start  = 1'b0;
        load_n = 1'b1;
        model_shift(o, k);
        chk("busy_cycles", nbusy, exp_busy);
        chk("done_cycle", done_at, exp_busy + 1);
        chk("busy_and_done", both, 0);
        chk("op_q", q, mq);
        chk("op_serial", serial_out, ms);
        @(negedge clk);
        chk("done_pulse_len", done, 0);
        chk("idle_busy", busy, 0);
        chk("hold_q", q, mq);
    endtask

    initial begin
        reset_n  = 1'b0;
        load_n   = 1'b1;
        load_val = '0;
        start    = 1'b0;
        op       = 2'd0;
        amount   = '0;
        repeat (2) @(negedge clk);
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_serial", serial_out, 0);
        reset_n = 1'b1;
        mq = 0;
        ms = 0;

        // directed cases
        do_load('hB4, 1'b0);
        run_op(0, 3);
        chk("lsr3_q", q, 'h16);
        chk("lsr3_serial", serial_out, 1);
        do_load('h96, 1'b0);
        run_op(1, 2);
        chk("asr2_q", q, 'hE5);
        chk("asr2_serial", serial_out, 1);
        do_load('h96, 1'b0);
        run_op(1, 15);
        chk("asr15_q", q, 'hFF);
        do_load('h81, 1'b0);
        run_op(2, 1);
        chk("lsl1_q", q, 'h02);
        chk("lsl1_serial", serial_out, 1);
        do_load('h01, 1'b0);
        run_op(3, 9);
        chk("ror9_q", q, 'h80);
        run_op(0, 0);
        chk("amt0_q", q, 'h80);
        do_load('h5A, 1'b1);
        do_load('hFF, 1'b0);
        run_op(0, 5);
        chk("lsr5_q", q, 'h07);

        // random mix of loads and operations
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_load(int'($urandom) & MASK, 1'($urandom));
            else
                run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        end

        // reset in the middle of a shift aborts it without a done pulse
        do_load('hFF, 1'b0);
        @(negedge clk);
        op     = 2'd0;
        amount = AW'(5);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_q", q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_serial", serial_out, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        reset_n = 1'b1;
        mq = 0;
        ms = 0;
        @(negedge clk);
        chk("post_abort_done", done, 0);
        chk("post_abort_busy", busy, 0);
        run_op(3, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
